// File: rtl/valid_array_ctrl.sv
// Rename/dispatch-side controller for the 4R/4W register valid array: source readiness
// lookup with writeback bypass, destination clears, and a 3-in/2-out writeback tag queue.
module valid_array_ctrl #(
    parameter int unsigned REGNAME_WIDTH = 5,
    parameter int unsigned OPRAND_WIDTH  = 16,
    parameter int unsigned WB_DEPTH      = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                disp_valid_i,
    output logic                                disp_ready_o,
    input  logic [3:0][REGNAME_WIDTH-1:0]       disp_src_i,
    input  logic [1:0][REGNAME_WIDTH-1:0]       disp_dst_i,
    input  logic [1:0]                          disp_dst_en_i,
    output logic                                iss_valid_o,
    output logic [3:0]                          iss_src_rdy_o,
    input  logic                                iss_ready_i,
    input  logic [2:0]                          cmp_valid_i,
    input  logic [2:0][REGNAME_WIDTH-1:0]       cmp_tag_i,
    output logic                                cmp_ready_o,
    output logic                                clr0_en_o,
    output logic [REGNAME_WIDTH-1:0]            clr0_addr_o,
    output logic [OPRAND_WIDTH-1:0]             clr0_data_o,
    output logic                                clr1_en_o,
    output logic [REGNAME_WIDTH-1:0]            clr1_addr_o,
    output logic [OPRAND_WIDTH-1:0]             clr1_data_o,
    output logic                                wb0_en_o,
    output logic [REGNAME_WIDTH-1:0]            wb0_addr_o,
    output logic [OPRAND_WIDTH-1:0]             wb0_data_o,
    output logic                                wb1_en_o,
    output logic [REGNAME_WIDTH-1:0]            wb1_addr_o,
    output logic [OPRAND_WIDTH-1:0]             wb1_data_o,
    output logic                                rd0_en_o,
    output logic [REGNAME_WIDTH-1:0]            rd0_addr_o,
    input  logic [OPRAND_WIDTH-1:0]             rd0_data_i,
    input  logic                                rd0_ready_i,
    output logic                                rd1_en_o,
    output logic [REGNAME_WIDTH-1:0]            rd1_addr_o,
    input  logic [OPRAND_WIDTH-1:0]             rd1_data_i,
    input  logic                                rd1_ready_i,
    output logic                                rd2_en_o,
    output logic [REGNAME_WIDTH-1:0]            rd2_addr_o,
    input  logic [OPRAND_WIDTH-1:0]             rd2_data_i,
    input  logic                                rd2_ready_i,
    output logic                                rd3_en_o,
    output logic [REGNAME_WIDTH-1:0]            rd3_addr_o,
    input  logic [OPRAND_WIDTH-1:0]             rd3_data_i,
    input  logic                                rd3_ready_i
);
    localparam int unsigned PtrW = $clog2(WB_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [REGNAME_WIDTH-1:0] tag_t;

    tag_t            wbq_q [WB_DEPTH];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, head_p1;
    logic [CntW-1:0] count_q, count_d;
    logic            iss_valid_q, iss_valid_d;
    logic [3:0]      rdy_q, rdy_d;

    logic [3:0]      rd_ready, rd_vbit, rdy;
    logic            stall, accept, rd_en;
    logic [1:0]      clr_en, wb_avail, wb_en;
    tag_t            wb_tag0, wb_tag1;
    logic [1:0]      pops, n_push;
    logic [2:0]      wr_en;
    logic [PtrW-1:0] wr_ptr [3];

    assign rd_ready = {rd3_ready_i, rd2_ready_i, rd1_ready_i, rd0_ready_i};
    assign rd_vbit  = {rd3_data_i[0], rd2_data_i[0], rd1_data_i[0], rd0_data_i[0]};

    assign stall        = iss_valid_q && !iss_ready_i;
    assign rd_en        = !rst && disp_valid_i && !stall;
    assign disp_ready_o = !rst && (!iss_valid_q || iss_ready_i) && (&rd_ready);
    assign accept       = disp_valid_i && disp_ready_o;
    assign clr_en       = {accept && disp_dst_en_i[1], accept && disp_dst_en_i[0]};

    function automatic logic clr_hit(input tag_t t);
        return (clr_en[0] && t == disp_dst_i[0]) || (clr_en[1] && t == disp_dst_i[1]);
    endfunction

    assign head_p1  = head_q + PtrW'(1);
    assign wb_tag0  = wbq_q[head_q];
    assign wb_tag1  = wbq_q[head_p1];
    assign wb_avail = {!rst && count_q >= CntW'(2), !rst && count_q >= CntW'(1)};
    // A completion for a register being reallocated this cycle is stale: drop it, still pop it.
    assign wb_en    = {wb_avail[1] && !clr_hit(wb_tag1), wb_avail[0] && !clr_hit(wb_tag0)};
    assign pops     = {1'b0, wb_avail[0]} + {1'b0, wb_avail[1]};

    assign cmp_ready_o = !rst && ((CntW'(WB_DEPTH) - count_q) >= CntW'(3));

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rdy[k] = rd_vbit[k] || (wb_en[0] && disp_src_i[k] == wb_tag0)
                                || (wb_en[1] && disp_src_i[k] == wb_tag1);
            if (k >= 2 && disp_dst_en_i[0] && disp_src_i[k] == disp_dst_i[0]) begin
                rdy[k] = 1'b0;
            end
        end
    end

    // Compact valid completion slots onto consecutive tail positions.
    always_comb begin
        n_push = '0;
        for (int s = 0; s < 3; s++) begin
            wr_en[s]  = 1'b0;
            wr_ptr[s] = tail_q + PtrW'(n_push);
            if (cmp_ready_o && cmp_valid_i[s]) begin
                wr_en[s] = 1'b1;
                n_push   = n_push + 2'd1;
            end
        end
    end

    always_comb begin
        head_d      = head_q + PtrW'(pops);
        tail_d      = tail_q + PtrW'(n_push);
        count_d     = count_q + CntW'(n_push) - CntW'(pops);
        iss_valid_d = accept ? 1'b1 : (iss_ready_i ? 1'b0 : iss_valid_q);
        rdy_d       = accept ? rdy : rdy_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            iss_valid_q <= 1'b0;
            rdy_q       <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            iss_valid_q <= iss_valid_d;
            rdy_q       <= rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (wr_en[s]) begin
                wbq_q[wr_ptr[s]] <= cmp_tag_i[s];
            end
        end
    end

    assign iss_valid_o   = iss_valid_q;
    assign iss_src_rdy_o = rdy_q;

    assign clr0_en_o   = clr_en[0];
    assign clr0_addr_o = disp_dst_i[0];
    assign clr0_data_o = '0;
    assign clr1_en_o   = clr_en[1];
    assign clr1_addr_o = disp_dst_i[1];
    assign clr1_data_o = '0;

    assign wb0_en_o   = wb_en[0];
    assign wb0_addr_o = wb_tag0;
    assign wb0_data_o = OPRAND_WIDTH'(1);
    assign wb1_en_o   = wb_en[1];
    assign wb1_addr_o = wb_tag1;
    assign wb1_data_o = OPRAND_WIDTH'(1);

    assign rd0_en_o   = rd_en;
    assign rd0_addr_o = disp_src_i[0];
    assign rd1_en_o   = rd_en;
    assign rd1_addr_o = disp_src_i[1];
    assign rd2_en_o   = rd_en;
    assign rd2_addr_o = disp_src_i[2];
    assign rd3_en_o   = rd_en;
    assign rd3_addr_o = disp_src_i[3];
endmodule

// File: tb/tb_valid_array_ctrl.sv
// Randomized bench for valid_array_ctrl against a queue/array reference model.
module tb_valid_array_ctrl;
    localparam int RW = 5;
    localparam int OW = 16;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 disp_valid, disp_ready, iss_valid, iss_ready, cmp_ready;
    logic [3:0][RW-1:0]   src;
    logic [1:0][RW-1:0]   dst;
    logic [1:0]           dst_en;
    logic [3:0]           iss_rdy;
    logic [2:0]           cmp_valid;
    logic [2:0][RW-1:0]   cmp_tag;
    logic                 clr_en [2];
    logic [RW-1:0]        clr_addr [2];
    logic [OW-1:0]        clr_data [2];
    logic                 wb_en [2];
    logic [RW-1:0]        wb_addr [2];
    logic [OW-1:0]        wb_data [2];
    logic                 rd_en [4];
    logic [RW-1:0]        rd_addr [4];
    logic [OW-1:0]        rd_data [4];
    logic                 rd_ready [4];

    valid_array_ctrl #(.REGNAME_WIDTH(RW), .OPRAND_WIDTH(OW), .WB_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .disp_valid_i(disp_valid), .disp_ready_o(disp_ready),
        .disp_src_i(src), .disp_dst_i(dst), .disp_dst_en_i(dst_en),
        .iss_valid_o(iss_valid), .iss_src_rdy_o(iss_rdy), .iss_ready_i(iss_ready),
        .cmp_valid_i(cmp_valid), .cmp_tag_i(cmp_tag), .cmp_ready_o(cmp_ready),
        .clr0_en_o(clr_en[0]), .clr0_addr_o(clr_addr[0]), .clr0_data_o(clr_data[0]),
        .clr1_en_o(clr_en[1]), .clr1_addr_o(clr_addr[1]), .clr1_data_o(clr_data[1]),
        .wb0_en_o(wb_en[0]), .wb0_addr_o(wb_addr[0]), .wb0_data_o(wb_data[0]),
        .wb1_en_o(wb_en[1]), .wb1_addr_o(wb_addr[1]), .wb1_data_o(wb_data[1]),
        .rd0_en_o(rd_en[0]), .rd0_addr_o(rd_addr[0]),
        .rd0_data_i(rd_data[0]), .rd0_ready_i(rd_ready[0]),
        .rd1_en_o(rd_en[1]), .rd1_addr_o(rd_addr[1]),
        .rd1_data_i(rd_data[1]), .rd1_ready_i(rd_ready[1]),
        .rd2_en_o(rd_en[2]), .rd2_addr_o(rd_addr[2]),
        .rd2_data_i(rd_data[2]), .rd2_ready_i(rd_ready[2]),
        .rd3_en_o(rd_en[3]), .rd3_addr_o(rd_addr[3]),
        .rd3_data_i(rd_data[3]), .rd3_ready_i(rd_ready[3])
    );

    int n_vec = 0;
    int n_err = 0;

    logic          arr [32];
    logic [RW-1:0] mq [$];
    logic          m_iv;
    logic [3:0]    m_rdy;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] rtag();
        return ($urandom_range(0, 3) == 0) ? RW'($urandom_range(0, 31)) : RW'($urandom_range(0, 7));
    endfunction

    initial begin
        logic          e_stall, e_dr, acc, e_cr, r;
        logic          e_clr [2];
        logic          e_wb [2];
        logic [RW-1:0] e_tag [2];
        logic [3:0]    e_rdy;
        int            nq, npop;
        bit            heavy;

        for (int i = 0; i < 32; i++) arr[i] = 1'($urandom_range(0, 1));
        m_iv  = 1'b0;
        m_rdy = '0;
        heavy = 1'b0;
        rst   = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc % 40 == 0) heavy = ($urandom_range(0, 1) == 1);
            rst        = (cyc < 3) || ($urandom_range(0, 199) == 0);
            disp_valid = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) begin
                src[k]      = rtag();
                rd_ready[k] = ($urandom_range(0, 15) != 0);
                rd_data[k]  = {15'($urandom), arr[src[k]]};
            end
            for (int j = 0; j < 2; j++) dst[j] = rtag();
            dst_en    = 2'($urandom_range(0, 3));
            iss_ready = ($urandom_range(0, 9) < 7);
            cmp_valid = heavy ? 3'b111 : 3'($urandom_range(0, 7));
            for (int s = 0; s < 3; s++) cmp_tag[s] = rtag();
            #1;

            e_stall = m_iv && !iss_ready;
            e_dr    = !rst && (!m_iv || iss_ready) && (&{rd_ready[3], rd_ready[2], rd_ready[1], rd_ready[0]});
            acc     = disp_valid && e_dr;
            for (int j = 0; j < 2; j++) e_clr[j] = acc && dst_en[j];
            nq = rst ? 0 : mq.size();
            for (int i = 0; i < 2; i++) begin
                e_wb[i]  = 1'b0;
                e_tag[i] = '0;
                if (i < nq) begin
                    e_tag[i] = mq[i];
                    e_wb[i]  = !((e_clr[0] && e_tag[i] == dst[0]) || (e_clr[1] && e_tag[i] == dst[1]));
                end
            end
            for (int k = 0; k < 4; k++) begin
                r = arr[src[k]];
                for (int i = 0; i < 2; i++) if (e_wb[i] && e_tag[i] == src[k]) r = 1'b1;
                if (k >= 2 && dst_en[0] && src[k] == dst[0]) r = 1'b0;
                e_rdy[k] = r;
            end
            e_cr = !rst && ((D - mq.size()) >= 3);

            check_eq("disp_ready", 64'(disp_ready), 64'(e_dr));
            check_eq("cmp_ready", 64'(cmp_ready), 64'(e_cr));
            check_eq("iss_valid", 64'(iss_valid), 64'(m_iv));
            check_eq("iss_src_rdy", 64'(iss_rdy), 64'(m_rdy));
            for (int k = 0; k < 4; k++) begin
                check_eq($sformatf("rd%0d_en", k), 64'(rd_en[k]), 64'(!rst && disp_valid && !e_stall));
                check_eq($sformatf("rd%0d_addr", k), 64'(rd_addr[k]), 64'(src[k]));
            end
            for (int j = 0; j < 2; j++) begin
                check_eq($sformatf("clr%0d_en", j), 64'(clr_en[j]), 64'(e_clr[j]));
                if (e_clr[j]) begin
                    check_eq($sformatf("clr%0d_addr", j), 64'(clr_addr[j]), 64'(dst[j]));
                    check_eq($sformatf("clr%0d_data", j), 64'(clr_data[j]), 64'(0));
                end
                check_eq($sformatf("wb%0d_en", j), 64'(wb_en[j]), 64'(e_wb[j]));
                if (e_wb[j]) begin
                    check_eq($sformatf("wb%0d_addr", j), 64'(wb_addr[j]), 64'(e_tag[j]));
                    check_eq($sformatf("wb%0d_data", j), 64'(wb_data[j]), 64'(1));
                end
            end

            if (rst) begin
                mq.delete();
                m_iv  = 1'b0;
                m_rdy = '0;
            end else begin
                npop = (mq.size() < 2) ? mq.size() : 2;
                for (int i = 0; i < npop; i++) void'(mq.pop_front());
                if (e_cr) for (int s = 0; s < 3; s++) if (cmp_valid[s]) mq.push_back(cmp_tag[s]);
                for (int j = 0; j < 2; j++) if (e_clr[j]) arr[dst[j]] = 1'b0;
                for (int i = 0; i < 2; i++) if (e_wb[i]) arr[e_tag[i]] = 1'b1;
                if (acc) begin
                    m_iv  = 1'b1;
                    m_rdy = e_rdy;
                end else if (iss_ready) begin
                    m_iv = 1'b0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/valid_array_ctrl.md
# valid_array_ctrl

Port controller that drives the 4-read/4-write register valid array from the rename/dispatch side. Each cycle it accepts a 2-wide dispatch bundle, reads the four source valid bits, clears the valid bits of the two destinations, and registers the per-source readiness toward issue. A 3-in/2-out writeback queue buffers function-unit completion tags and drains them onto the two writeback write ports that set valid bits.

## Interface
- REGNAME_WIDTH, 5, register tag width
- OPRAND_WIDTH, 16, array data width; bit 0 is the valid flag
- WB_DEPTH, 8, writeback queue entries (≥4, power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high. One clock; all state on rising edge of clk.
- disp_valid_i  in  1  dispatch bundle valid
- disp_ready_o  out  1  bundle accepted when valid && ready
- disp_src_i  in  4×REGNAME_WIDTH  sources: [0],[1] = inst0 A/B; [2],[3] = inst1 A/B
- disp_dst_i  in  2×REGNAME_WIDTH  destinations of inst0/inst1
- disp_dst_en_i  in  2  destination present
- iss_valid_o  out  1  registered bundle valid toward issue
- iss_src_rdy_o  out  4  registered source ready bits
- iss_ready_i  in  1  issue consumes bundle
- cmp_valid_i  in  3  completion slots valid
- cmp_tag_i  in  3×REGNAME_WIDTH  completed destination tags
- cmp_ready_o  out  1  all-or-nothing acceptance of the completion group
- clr{0,1}_en_o / clr{0,1}_addr_o / clr{0,1}_data_o  out  1 / REGNAME_WIDTH / OPRAND_WIDTH  → array write ports 11/12
- wb{0,1}_en_o / wb{0,1}_addr_o / wb{0,1}_data_o  out  1 / REGNAME_WIDTH / OPRAND_WIDTH  → array write ports 21/22
- rd{0..3}_en_o / rd{0..3}_addr_o  out  1 / REGNAME_WIDTH  → array read ports 11,12,21,22
- rd{0..3}_data_i / rd{0..3}_ready_i  in  OPRAND_WIDTH / 1  combinational read return

## Operation
- Reads: rd{k}_en_o = disp_valid_i && !stall_out; rd{k}_addr_o = disp_src_i[k]. Read is combinational; data and ready sampled the same cycle.
- disp_ready_o = (!iss_valid_o || iss_ready_i) && all rd{k}_ready_i. Reads may be presented while disp_ready_o=0; no array writes occur then.
- Source readiness: rdy[k] = rd{k}_data_i[0] OR (tag equals a wb port enabled this cycle). For k=2,3: forced 0 if disp_dst_en_i[0] && disp_src_i[k]==disp_dst_i[0] (intra-bundle dependency overrides bypass).
- Clears on accept: clr{j}_en_o = accept && disp_dst_en_i[j]; data = all zeros. Equal dst0==dst1 legal; both writes issued.
- Writeback queue: circular, head/tail pointers wrap mod WB_DEPTH, count 0..WB_DEPTH. Push compacts valid slots in order 0,1,2. cmp_ready_o = (WB_DEPTH − count) ≥ 3.
- Drain: wb0 = head, wb1 = head+1; enables = count≥1 / count≥2; data = 1 zero-extended. Pops = number of enabled wb ports; push and pop same cycle allowed; count updated as count + pushes − pops.
- Collision: a wb entry whose tag equals an enabled clear this cycle has its wb_en forced 0 and is still popped (stale completion dropped); no bypass credit.
- Output register: loads iss_src_rdy_o and sets iss_valid_o on accept; clears iss_valid_o when iss_ready_i && !accept.

## Timing
- Reset: iss_valid_o=0, iss_src_rdy_o=0, count=0, head=tail=0; all *_en_o=0 during rst and the cycle it deasserts with empty queue; cmp_ready_o=1 once rst is low.
- Dispatch accepted cycle N → iss_valid_o in N+1; clears land in array at edge ending N.
- Completion accepted cycle N → earliest wb write N+1 (no fall-through).
- Drain rate 2/cycle max; fill 3/cycle max.
- rst mid-operation flushes queue and output register; in-flight completions lost.

## Test plan
- Reset then idle → all enables 0, iss_valid_o=0, cmp_ready_o=1.
- Array holds r3 valid, r4 invalid; dispatch src {3,4,3,4}, dst {7,8} → rd addrs 3,4,3,4, clr writes r7,r8 with 0; next cycle iss_src_rdy_o=4'b0101.
- Inst0 dst=5, inst1 src A=5 with r5 valid → iss_src_rdy_o[2]=0.
- Push tags {9,10,11} cycle N → cycle N+1 wb r9,r10; N+2 wb r11; dispatch reading r11 in N+2 gets rdy=1 via bypass.
- Fill queue to 6 without draining capacity → cmp_ready_o=0 at count 6; remains 0 until count ≤5; tags emerge in push order across pointer wrap.
- iss_ready_i=0 with iss_valid_o=1 → disp_ready_o=0, no clr writes, output held; wb tag colliding with clr tag same cycle → wb_en suppressed, entry popped.
